// File: rtl/inverse_moving_average_8_tap.sv
// Inverts an 8-tap moving average: x[n] = 8*(y[n] - y[n-1]) + x[n-8], with valid/ready handshake.
// Optional macro INV_MAVG_SATURATE_EN clamps out-of-range results instead of wrapping them.
module inverse_moving_average_8_tap #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_primed,
    output logic                 ovf
);

    logic signed [DW-1:0] y_prev;
    logic signed [DW-1:0] x_dly [8];
    logic [3:0]           prime_cnt;

    logic                 accept;
    logic signed [DW:0]   diff;
    logic signed [DW+3:0] scaled;
    logic signed [DW+4:0] sum;
    logic                 out_of_range;
    logic signed [DW-1:0] reduced;

    assign in_ready = (!out_valid || out_ready) && !clr && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        diff   = $signed({in_data[DW-1], in_data}) - $signed({y_prev[DW-1], y_prev});
        scaled = $signed({diff, 3'b000});
        sum    = $signed({scaled[DW+3], scaled}) + $signed({{5{x_dly[7][DW-1]}}, x_dly[7]});
        // In range only when every bit above the DW-bit sign position matches it.
        out_of_range = !((&sum[DW+4:DW-1]) || !(|sum[DW+4:DW-1]));
`ifdef INV_MAVG_SATURATE_EN
        if (out_of_range)
            reduced = sum[DW+4] ? $signed({1'b1, {(DW-1){1'b0}}}) : $signed({1'b0, {(DW-1){1'b1}}});
        else
            reduced = sum[DW-1:0];
`else
        reduced = sum[DW-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            y_prev    <= '0;
            prime_cnt <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < 8; i++)
                x_dly[i] <= '0;
            if (reset)
                out_data <= '0;
        end else if (accept) begin
            y_prev    <= in_data;
            x_dly[0]  <= reduced;
            for (int unsigned i = 1; i < 8; i++)
                x_dly[i] <= x_dly[i-1];
            out_data  <= reduced;
            out_valid <= 1'b1;
            if (out_of_range)
                ovf <= 1'b1;
            if (prime_cnt != 4'd8)
                prime_cnt <= prime_cnt + 4'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_primed = (prime_cnt == 4'd8);

endmodule

// File: tb/tb_inverse_moving_average_8_tap.sv
// Self-checking bench for inverse_moving_average_8_tap: vector table, directed corner sequences, random run vs model.
module tb_inverse_moving_average_8_tap;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_data;
    logic                 out_primed;
    logic                 ovf;

    inverse_moving_average_8_tap #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_primed(out_primed), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: histories as queues of accepted inputs and produced outputs.
    int ys[$];
    int xs[$];
    bit m_ov  = 1'b0;
    int m_od  = 0;
    bit m_ovf = 1'b0;

    typedef struct {
        bit iv;
        int d;
        bit ordy;
        int exp_d;
        bit exp_v;
        bit exp_p;
        bit exp_ovf;
    } vec_t;
    vec_t tbl[12];

    function automatic int reduce(int s);
        logic signed [15:0] t;
`ifdef INV_MAVG_SATURATE_EN
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        t = s[15:0];
        return int'(t);
`endif
    endfunction

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(bit rst, bit iv, int d, bit ordy, bit c);
        bit acc;
        bit rdy;
        int y, yp, x8, s;
        logic signed [15:0] t;
        t = d[15:0];
        reset = rst; in_valid = iv; in_data = t; out_ready = ordy; clr = c;
        #1;
        rdy = !rst && !c && (!m_ov || ordy);
        acc = rdy && iv;
        check("in_ready", in_ready, rdy);
        @(posedge clk);
        if (rst) begin
            ys.delete(); xs.delete(); m_ov = 0; m_od = 0; m_ovf = 0;
        end else if (c) begin
            ys.delete(); xs.delete(); m_ov = 0; m_ovf = 0;
        end else if (acc) begin
            y  = int'(t);
            yp = (ys.size() > 0) ? ys[ys.size()-1] : 0;
            x8 = (xs.size() >= 8) ? xs[xs.size()-8] : 0;
            s  = 8 * (y - yp) + x8;
            if (s > 32767 || s < -32768) m_ovf = 1;
            m_od = reduce(s);
            ys.push_back(y);
            xs.push_back(m_od);
            if (xs.size() > 8) void'(xs.pop_front());
            if (ys.size() > 8) void'(ys.pop_front());
            m_ov = 1;
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
        #1;
        check("out_valid", out_valid, m_ov);
        check("out_data", $signed(out_data), m_od);
        check("out_primed", out_primed, xs.size() >= 8);
        check("ovf", ovf, m_ovf);
    endtask

    initial begin
        int held;
        int hist[8];
        int x, sum;

        for (int i = 0; i < 12; i++) begin
            tbl[i].iv      = 1;
            tbl[i].d       = (i == 0) ? 100 : 0;
            tbl[i].ordy    = 1;
            tbl[i].exp_d   = (i == 0 || i == 8) ? 800 : ((i == 1 || i == 9) ? -800 : 0);
            tbl[i].exp_v   = 1;
            tbl[i].exp_p   = (i >= 7);
            tbl[i].exp_ovf = 0;
        end

        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 123, 1, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_valid", out_valid, 0);

        // Impulse response
        for (int i = 0; i < 12; i++) begin
            cyc(0, tbl[i].iv, tbl[i].d, tbl[i].ordy, 0);
            check("imp_data", $signed(out_data), tbl[i].exp_d);
            check("imp_valid", out_valid, tbl[i].exp_v);
            check("imp_primed", out_primed, tbl[i].exp_p);
            check("imp_ovf", ovf, tbl[i].exp_ovf);
        end

        // Overflow
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, -32768, 1, 0);
        cyc(0, 1, 32767, 1, 0);
`ifdef INV_MAVG_SATURATE_EN
        check("ovf_data", $signed(out_data), 32767);
`else
        check("ovf_data", $signed(out_data), -8);
`endif
        check("ovf_flag", ovf, 1);

        // Backpressure
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 300, 1, 0);
        cyc(0, 1, -200, 1, 0);
        cyc(0, 1, 1000, 1, 0);
        cyc(0, 1, -700, 1, 0);
        check("bp_pre", $signed(out_data), -13600);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 5555, 0, 0);
            check("bp_hold", $signed(out_data), held);
            check("bp_in_ready", in_ready, 0);
        end
        cyc(0, 1, 450, 1, 0);
        check("bp_next", $signed(out_data), 9200);

        // Clear
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 50, 1, 0);
        cyc(0, 1, 50, 1, 1);
        check("clr_valid", out_valid, 0);
        check("clr_ovf", ovf, 0);
        check("clr_primed", out_primed, 0);
        cyc(0, 1, 50, 1, 0);
        check("clr_next", $signed(out_data), 400);

        // Reset mid-stream
        cyc(0, 1, 77, 1, 0);
        cyc(0, 1, 88, 0, 0);
        check("mid_valid_pre", out_valid, 1);
        cyc(1, 1, 99, 0, 0);
        check("mid_rst_data", $signed(out_data), 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        cyc(0, 1, 10, 1, 0);
        check("mid_first", $signed(out_data), 80);

        // Round-trip through an exact 8-tap averager
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) hist[i] = 0;
        for (int n = 0; n < 60; n++) begin
            x = (int'($urandom_range(0, 250)) - 125) * 8;
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = x;
            sum = 0;
            for (int i = 0; i < 8; i++) sum += hist[i];
            cyc(0, 1, sum / 8, 1, 0);
            check("rt_x", $signed(out_data), x);
            check("rt_ovf", ovf, 0);
        end

        // Random traffic against the model
        cyc(1, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 150) == 0, ($urandom % 4) != 0,
                ($urandom % 2) ? int'($urandom_range(0, 200)) - 100 : int'($urandom),
                ($urandom % 3) != 0, ($urandom % 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
